// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg                                                             |
// | Shared register-file widths and the writeback queue entry type.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package core_pkg;

  localparam int CORE_ADDRESS_WIDTH = 5;
  localparam int CORE_DATA_WIDTH    = 32;

  typedef struct packed {
    logic [CORE_ADDRESS_WIDTH-1:0] rd;
    logic [CORE_DATA_WIDTH-1:0]    data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_lookup                                                            |
// | Combinational youngest-match search over the live queue entries.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_lookup
  import core_pkg::*;
#(
  parameter int ADDRESS_WIDTH = CORE_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = CORE_DATA_WIDTH,
  parameter int DEPTH         = 4
) (
  input  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] entry_rd,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]    entry_data,
  input  logic [$clog2(DEPTH)-1:0]            head,
  input  logic [$clog2(DEPTH):0]              count,
  input  logic [ADDRESS_WIDTH-1:0]            addr,
  output logic                                hit,
  output logic [DATA_WIDTH-1:0]               data
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [DEPTH-1:0][PTR_WIDTH-1:0] w_idx;
  logic [DEPTH-1:0]                w_match;

  // Slot i is the i-th oldest entry; it is live only while i < count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign w_idx[i]   = head + PTR_WIDTH'(i);
    assign w_match[i] = (count > (PTR_WIDTH+1)'(i)) && (entry_rd[w_idx[i]] == addr);
  end

  // Scan oldest to youngest so the last hit is the youngest value.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (addr != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_match[i]) begin
          hit  = 1'b1;
          data = entry_data[w_idx[i]];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_write_queue                                                       |
// | Dual-lane in-order write buffer draining into the single RF port.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_write_queue
  import core_pkg::*;
#(
  parameter int ADDRESS_WIDTH = CORE_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = CORE_DATA_WIDTH,
  parameter int DEPTH         = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb0_valid,
  input  logic [ADDRESS_WIDTH-1:0]  wb0_rd,
  input  logic [DATA_WIDTH-1:0]     wb0_data,
  input  logic                      wb1_valid,
  input  logic [ADDRESS_WIDTH-1:0]  wb1_rd,
  input  logic [DATA_WIDTH-1:0]     wb1_data,
  output logic                      in_ready,
  output logic                      WE3,
  output logic [ADDRESS_WIDTH-1:0]  AD3,
  output logic [DATA_WIDTH-1:0]     WD3,
  input  logic [ADDRESS_WIDTH-1:0]  lk1_addr,
  output logic                      lk1_hit,
  output logic [DATA_WIDTH-1:0]     lk1_data,
  input  logic [ADDRESS_WIDTH-1:0]  lk2_addr,
  output logic                      lk2_hit,
  output logic [DATA_WIDTH-1:0]     lk2_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int                 PTR_WIDTH   = $clog2(DEPTH);
  localparam logic [PTR_WIDTH:0] C_READY_MAX = (PTR_WIDTH+1)'(DEPTH - 2);

  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] r_rd;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    r_data;
  logic [PTR_WIDTH-1:0]                r_head;
  logic [PTR_WIDTH-1:0]                r_tail;
  logic [PTR_WIDTH:0]                  r_count;

  logic                 w_push0;
  logic                 w_push1;
  logic                 w_pop;
  logic [PTR_WIDTH:0]   w_push_cnt;
  logic [PTR_WIDTH-1:0] w_slot1;

  // Ready depends on registered occupancy only, so two slots are always free.
  assign in_ready   = (r_count <= C_READY_MAX);
  assign w_push0    = wb0_valid && in_ready && (wb0_rd != '0);
  assign w_push1    = wb1_valid && in_ready && (wb1_rd != '0);
  assign w_pop      = (r_count != '0);
  assign w_push_cnt = (PTR_WIDTH+1)'(w_push0) + (PTR_WIDTH+1)'(w_push1);
  assign w_slot1    = w_push0 ? (r_tail + PTR_WIDTH'(1)) : r_tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + PTR_WIDTH'(1);
      end
      r_tail  <= r_tail + w_push_cnt[PTR_WIDTH-1:0];
      r_count <= r_count + w_push_cnt - (PTR_WIDTH+1)'(w_pop);
    end
  end

  // Entry storage carries no reset; liveness is tracked by head/count.
  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_rd[r_tail]   <= wb0_rd;
      r_data[r_tail] <= wb0_data;
    end
    if (w_push1) begin
      r_rd[w_slot1]   <= wb1_rd;
      r_data[w_slot1] <= wb1_data;
    end
  end

  assign WE3   = w_pop;
  assign AD3   = w_pop ? r_rd[r_head]   : '0;
  assign WD3   = w_pop ? r_data[r_head] : '0;
  assign count = r_count;

  wb_lookup #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .DEPTH         (DEPTH)
  ) u_lookup1 (
    .entry_rd   (r_rd),
    .entry_data (r_data),
    .head       (r_head),
    .count      (r_count),
    .addr       (lk1_addr),
    .hit        (lk1_hit),
    .data       (lk1_data)
  );

  wb_lookup #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .DEPTH         (DEPTH)
  ) u_lookup2 (
    .entry_rd   (r_rd),
    .entry_data (r_data),
    .head       (r_head),
    .count      (r_count),
    .addr       (lk2_addr),
    .hit        (lk2_hit),
    .data       (lk2_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_write_queue                                                    |
// | Scoreboard bench: queued writes model drain order, bypass and count. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_wb_write_queue;
  import core_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb0_valid, wb1_valid;
  logic [AW-1:0] wb0_rd, wb1_rd;
  logic [DW-1:0] wb0_data, wb1_data;
  logic          in_ready;
  logic          WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;
  logic [AW-1:0] lk1_addr, lk2_addr;
  logic          lk1_hit, lk2_hit;
  logic [DW-1:0] lk1_data, lk2_data;
  logic [$clog2(DEPTH):0] count;

  wb_write_queue #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb0_valid (wb0_valid),
    .wb0_rd    (wb0_rd),
    .wb0_data  (wb0_data),
    .wb1_valid (wb1_valid),
    .wb1_rd    (wb1_rd),
    .wb1_data  (wb1_data),
    .in_ready  (in_ready),
    .WE3       (WE3),
    .AD3       (AD3),
    .WD3       (WD3),
    .lk1_addr  (lk1_addr),
    .lk1_hit   (lk1_hit),
    .lk1_data  (lk1_data),
    .lk2_addr  (lk2_addr),
    .lk2_hit   (lk2_hit),
    .lk2_data  (lk2_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  wb_entry_t     exp_q[$];
  wb_entry_t     mon_e;
  logic [DW-1:0] rf [32];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          acc;
  logic          saw_full;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register file model: commits each write the queue presents mid-cycle.
  always @(negedge clk) begin
    if (!rst && WE3) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("drain_rd", 64'(AD3), 64'(mon_e.rd));
        check_eq("drain_data", 64'(WD3), 64'(mon_e.data));
      end
      rf[AD3] = WD3;
    end
  end

  function automatic void model_lookup(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (a != '0) begin
      foreach (exp_q[i]) begin
        if (exp_q[i].rd == a) begin
          h = 1'b1;
          d = exp_q[i].data;
        end
      end
    end
  endfunction

  // One clock: check state against the model, then present the next inputs.
  task automatic cycle(input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2, output logic ok);
    logic          h;
    logic [DW-1:0] d;
    logic          rdy;
    @(posedge clk);
    #1;
    lk1_addr = a1;
    lk2_addr = a2;
    #1;
    rdy = (exp_q.size() <= DEPTH - 2);
    check_eq("count", 64'(count), 64'(exp_q.size()));
    check_eq("in_ready", 64'(in_ready), 64'(rdy));
    check_eq("we3", 64'(WE3), 64'(exp_q.size() != 0));
    model_lookup(a1, h, d);
    check_eq("lk1_hit", 64'(lk1_hit), 64'(h));
    check_eq("lk1_data", 64'(lk1_data), 64'(d));
    model_lookup(a2, h, d);
    check_eq("lk2_hit", 64'(lk2_hit), 64'(h));
    check_eq("lk2_data", 64'(lk2_data), 64'(d));
    wb0_valid = v0; wb0_rd = r0; wb0_data = d0;
    wb1_valid = v1; wb1_rd = r1; wb1_data = d1;
    if (rdy && v0 && r0 != '0) exp_q.push_back('{rd: r0, data: d0});
    if (rdy && v1 && r1 != '0) exp_q.push_back('{rd: r1, data: d1});
    ok = rdy;
  endtask

  task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic ok;
    cycle(1'b0, '0, '0, 1'b0, '0, '0, a1, a2, ok);
  endtask

  // Upstream holds both lanes until the queue accepts them.
  task automatic push_hold(input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                           input logic [AW-1:0] r1, input logic [DW-1:0] d1);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      cycle(1'b1, r0, d0, 1'b1, r1, d1, r0, r1, ok);
      if (!ok) saw_full = 1'b1;
    end
    if (!ok) check_eq("push_hold_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle('0, '0);
    idle('0, '0);
    check_eq("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    foreach (rf[i]) rf[i] = '0;
    rst = 1'b1;
    wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
    lk1_addr = 5'd5; lk2_addr = 5'd0;
    saw_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_we3", 64'(WE3), 64'd0);
    check_eq("rst_ad3", 64'(AD3), 64'd0);
    check_eq("rst_wd3", 64'(WD3), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_lk1_hit", 64'(lk1_hit), 64'd0);
    check_eq("rst_lk1_data", 64'(lk1_data), 64'd0);
    rst = 1'b0;
    idle('0, '0);

    // Single push
    cycle(1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0, '0, '0, acc);
    idle(5'd5, '0);
    check_eq("single_we3", 64'(WE3), 64'd1);
    check_eq("single_ad3", 64'(AD3), 64'd5);
    check_eq("single_wd3", 64'(WD3), 64'h1234_5678);
    idle('0, '0);
    check_eq("single_we3_off", 64'(WE3), 64'd0);
    check_eq("single_rf5", 64'(rf[5]), 64'h1234_5678);

    // Dual push ordering
    cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, '0, '0, acc);
    idle(5'd3, 5'd4);
    check_eq("dual_count2", 64'(count), 64'd2);
    check_eq("dual_ad3_first", 64'(AD3), 64'd3);
    idle('0, '0);
    check_eq("dual_count1", 64'(count), 64'd1);
    check_eq("dual_ad3_second", 64'(AD3), 64'd4);
    idle('0, '0);
    check_eq("dual_count0", 64'(count), 64'd0);

    // Backpressure: three back-to-back dual pushes into DEPTH=4
    push_hold(5'd10, 32'h100, 5'd11, 32'h101);
    push_hold(5'd12, 32'h102, 5'd13, 32'h103);
    push_hold(5'd14, 32'h104, 5'd15, 32'h105);
    drain();
    check_eq("backpressure_seen", 64'(saw_full), 64'd1);
    check_eq("bp_rf15", 64'(rf[15]), 64'h105);
    check_eq("bp_rf10", 64'(rf[10]), 64'h100);

    // Same rd on both lanes, bypass sees the younger value
    cycle(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, '0, '0, acc);
    idle(5'd7, 5'd7);
    check_eq("same_rd_hit", 64'(lk1_hit), 64'd1);
    check_eq("same_rd_data", 64'(lk1_data), 64'h2);
    drain();
    idle(5'd7, '0);
    check_eq("same_rd_hit_after", 64'(lk1_hit), 64'd0);
    check_eq("same_rd_rf7", 64'(rf[7]), 64'h2);

    // x0 writes are dropped
    cycle(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd9, 32'h5, '0, '0, acc);
    idle(5'd0, 5'd9);
    check_eq("x0_count", 64'(count), 64'd1);
    check_eq("x0_lk_hit", 64'(lk1_hit), 64'd0);
    drain();
    check_eq("x0_rf9", 64'(rf[9]), 64'h5);
    check_eq("x0_rf0", 64'(rf[0]), 64'h0);

    // Asynchronous reset mid-drain
    cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, '0, '0, acc);
    cycle(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23, '0, '0, acc);
    idle('0, '0);
    check_eq("pre_rst_count", 64'(count), 64'd3);
    check_eq("pre_rst_we3", 64'(WE3), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_we3", 64'(WE3), 64'd0);
    check_eq("async_rst_count", 64'(count), 64'd0);
    check_eq("async_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    #1;
    rst = 1'b0;
    idle('0, '0);

    // Random traffic with collisions, x0 and bypass probes
    for (int n = 0; n < 60; n++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
